// File: rtl/diff_demo_pkg.sv
// Shared configuration and types for the diff_demo datapath blocks.
// Holds PE-matrix/buffer sizing and the write-back arbiter state encoding.
package diff_demo_pkg;

  localparam int CONF_PE_ROW       = 4;
  localparam int CONF_FM_BUF_DEPTH = 512;
  localparam int WB_BYTES_PER_WORD = 9;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_RUN,
    WB_FLUSH,
    WB_DONE
  } wb_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: one-hot grant searched from the registered pointer,
// pointer advances past the granted requester whenever a grant is issued.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] sel;
  logic [PW-1:0] ptr_nxt;
  logic [PW:0]   cand_w;
  logic [PW:0]   nxt_w;
  logic          hit;

  // Scan requesters starting at ptr, wrapping modulo N_REQ; first valid wins.
  always_comb begin
    hit    = 1'b0;
    sel    = '0;
    cand_w = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_w = {1'b0, ptr} + (PW+1)'(k);
      if (cand_w >= (PW+1)'(N_REQ)) cand_w = cand_w - (PW+1)'(N_REQ);
      if (!hit && req[cand_w[PW-1:0]]) begin
        hit = 1'b1;
        sel = cand_w[PW-1:0];
      end
    end
  end

  always_comb begin
    nxt_w   = {1'b0, sel} + (PW+1)'(1);
    ptr_nxt = (nxt_w >= (PW+1)'(N_REQ)) ? '0 : nxt_w[PW-1:0];
  end

  assign gnt = (en && hit) ? (N_REQ'(1) << sel) : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && hit) begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/diff_wb_arbiter.sv
// Write-back arbiter: round-robin merges PE-row byte streams, packs them LSB-first
// into fm buffer words and writes them from an auto-incrementing address.
module diff_wb_arbiter
  import diff_demo_pkg::*;
#(
  parameter int N_REQ          = CONF_PE_ROW,
  parameter int FM_DEPTH       = CONF_FM_BUF_DEPTH,
  parameter int BYTES_PER_WORD = WB_BYTES_PER_WORD,
  parameter int DATA_W         = 8,
  parameter int AW             = $clog2(FM_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic [AW-1:0]                    base_addr,
  input  logic                             flush,
  input  logic [N_REQ-1:0]                 req_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0]     req_data,
  output logic [N_REQ-1:0]                 req_ready,
  output logic                             fm_wr_en,
  output logic [AW-1:0]                    fm_wr_addr,
  output logic [BYTES_PER_WORD*DATA_W-1:0] fm_din,
  output logic                             busy,
  output logic                             done,
  output logic                             wrap_err
);

  localparam int CW = $clog2(BYTES_PER_WORD);

  wb_arb_state_e state, state_nxt;

  logic [AW-1:0]                         addr;
  logic [AW-1:0]                         addr_inc;
  logic                                  addr_wrap;
  logic [CW-1:0]                         cnt;
  logic                                  last_lane;
  logic [BYTES_PER_WORD-1:0][DATA_W-1:0] word_p0;
  logic [BYTES_PER_WORD-1:0][DATA_W-1:0] word_nxt;
  logic [N_REQ-1:0]                      gnt;
  logic                                  xfer;
  logic [DATA_W-1:0]                     acc_byte;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (state == WB_RUN),
    .req   (req_valid),
    .gnt   (gnt)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;
  assign busy      = (state == WB_RUN) || (state == WB_FLUSH);
  assign done      = (state == WB_DONE);

  // Grant is one-hot, so OR-ing masked lanes selects the accepted byte.
  always_comb begin
    acc_byte = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) acc_byte = acc_byte | req_data[i];
    end
  end

  always_comb begin
    word_nxt      = word_p0;
    word_nxt[cnt] = acc_byte;
  end

  assign last_lane = (cnt == CW'(BYTES_PER_WORD - 1));
  assign addr_wrap = (addr == AW'(FM_DEPTH - 1));
  assign addr_inc  = addr_wrap ? '0 : addr + 1'b1;

  always_comb begin
    state_nxt = state;
    case (state)
      WB_IDLE:  if (start) state_nxt = WB_RUN;
      WB_RUN:   if (flush) state_nxt = WB_FLUSH;
      // A partial word is written first; DONE follows once the lane count is clear.
      WB_FLUSH: if (cnt == '0) state_nxt = WB_DONE;
      WB_DONE:  state_nxt = WB_IDLE;
      default:  state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= WB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Stage p0: byte lanes accumulate in word_p0; completed words register to fm_din.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr       <= '0;
      cnt        <= '0;
      word_p0    <= '0;
      fm_wr_en   <= 1'b0;
      fm_wr_addr <= '0;
      fm_din     <= '0;
      wrap_err   <= 1'b0;
    end else begin
      fm_wr_en <= 1'b0;
      case (state)
        WB_IDLE: begin
          if (start) begin
            addr     <= base_addr;
            cnt      <= '0;
            word_p0  <= '0;
            wrap_err <= 1'b0;
          end
        end
        WB_RUN: begin
          if (xfer) begin
            if (last_lane) begin
              fm_din     <= word_nxt;
              fm_wr_en   <= 1'b1;
              fm_wr_addr <= addr;
              addr       <= addr_inc;
              wrap_err   <= wrap_err | addr_wrap;
              cnt        <= '0;
              word_p0    <= '0;
            end else begin
              word_p0 <= word_nxt;
              cnt     <= cnt + 1'b1;
            end
          end
        end
        WB_FLUSH: begin
          if (cnt != '0) begin
            fm_din     <= word_p0;
            fm_wr_en   <= 1'b1;
            fm_wr_addr <= addr;
            addr       <= addr_inc;
            wrap_err   <= wrap_err | addr_wrap;
            cnt        <= '0;
            word_p0    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_diff_wb_arbiter.sv
// Scoreboard bench for diff_wb_arbiter: expected buffer writes are queued as
// stimulus is prepared and popped as the DUT issues fm_wr_en.
module tb_diff_wb_arbiter;

  localparam int AW = 9;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [AW-1:0]    base_addr;
  logic             flush;
  logic [3:0]       req_valid;
  logic [3:0][7:0]  req_data;
  logic [3:0]       req_ready;
  logic             fm_wr_en;
  logic [AW-1:0]    fm_wr_addr;
  logic [71:0]      fm_din;
  logic             busy;
  logic             done;
  logic             wrap_err;

  diff_wb_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fm_wr_en   (fm_wr_en),
    .fm_wr_addr (fm_wr_addr),
    .fm_din     (fm_din),
    .busy       (busy),
    .done       (done),
    .wrap_err   (wrap_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [AW+71:0] exp_q [$];
  logic [7:0]     rowbuf [4][32];
  int             rowlen [4];
  int             rowpos [4];
  logic [7:0]     stream [64];
  int             slen;

  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_wr_cyc = 0;
  int last_acc_cyc = 0;

  task automatic check(input string tag, input logic [71:0] act, input logic [71:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] bval(input int row, input int j);
    return 8'(row * 16 + j + 1);
  endfunction

  task automatic load_rows(input int n0, input int n1, input int n2, input int n3);
    rowlen[0] = n0; rowlen[1] = n1; rowlen[2] = n2; rowlen[3] = n3;
    for (int i = 0; i < 4; i++) begin
      rowpos[i] = 0;
      for (int j = 0; j < rowlen[i]; j++) rowbuf[i][j] = bval(i, j);
    end
  endtask

  function automatic int remaining();
    int r = 0;
    for (int i = 0; i < 4; i++) r += rowlen[i] - rowpos[i];
    return r;
  endfunction

  task automatic refresh(input bit flush_last);
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (rowpos[i] < rowlen[i]);
      req_data[i]  = req_valid[i] ? rowbuf[i][rowpos[i]] : 8'h00;
    end
    flush = flush_last && (remaining() == 1);
  endtask

  // Pack the expected byte stream LSB-first into 9-byte words; partial word zero-padded.
  task automatic push_expected(input logic [AW-1:0] base);
    logic [71:0]   w;
    logic [AW-1:0] a;
    int            lane;
    a = base; w = '0; lane = 0;
    for (int k = 0; k < slen; k++) begin
      w[lane*8 +: 8] = stream[k];
      lane++;
      if (lane == 9) begin
        exp_q.push_back({a, w});
        a++;
        w = '0;
        lane = 0;
      end
    end
    if (lane > 0) exp_q.push_back({a, w});
  endtask

  always begin
    logic [AW+71:0] e;
    @(negedge clk);
    cyc++;
    if (rst_n && |(req_valid & req_ready)) last_acc_cyc = cyc;
    if (fm_wr_en) begin
      last_wr_cyc = cyc;
      check("wr_expected", 72'(exp_q.size() > 0), 72'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_addr", 72'(fm_wr_addr), 72'(e[AW+71:72]));
        check("wr_data", fm_din, e[71:0]);
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic start_layer(input logic [AW-1:0] base);
    @(posedge clk); #1;
    req_valid = '0; req_data = '0; flush = 1'b0;
    start = 1'b1; base_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_run", 72'(busy), 72'(1));
    check("wrap_clr", 72'(wrap_err), 72'(0));
    @(posedge clk); #1;
  endtask

  task automatic send_all(input bit flush_last);
    logic [3:0] acc;
    int guard = 0;
    while (remaining() > 0 && guard < 300) begin
      refresh(flush_last);
      @(negedge clk);
      acc = req_valid & req_ready;
      check("gnt_1hot", 72'($onehot0(req_ready)), 72'(1));
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) if (acc[i]) rowpos[i]++;
      guard++;
    end
    check("all_sent", 72'(remaining()), 72'(0));
    refresh(1'b0);
  endtask

  task automatic finish_layer(input bit do_flush, input bit chk_done_lat, input bit chk_wr_lat);
    int d0;
    int guard;
    d0 = done_cnt;
    guard = 0;
    if (do_flush) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    while (done_cnt == d0 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    @(negedge clk);
    check("done_cnt", 72'(done_cnt - d0), 72'(1));
    check("wr_left", 72'(exp_q.size()), 72'(0));
    if (chk_done_lat) check("done_lat", 72'(done_cyc - last_wr_cyc), 72'(1));
    if (chk_wr_lat) check("wr_lat", 72'(last_wr_cyc - last_acc_cyc), 72'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = '0; flush = 1'b0;
    req_valid = 4'hF; req_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 72'(req_ready), 72'(0));
    check("rst_busy", 72'(busy), 72'(0));
    check("rst_done", 72'(done), 72'(0));
    check("rst_wr_en", 72'(fm_wr_en), 72'(0));
    check("rst_wrap", 72'(wrap_err), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = '0;

    // Row 0 sends 0x01..0x09 into base 10.
    load_rows(9, 0, 0, 0);
    slen = 9;
    for (int k = 0; k < slen; k++) stream[k] = bval(0, k);
    push_expected(9'd10);
    start_layer(9'd10);
    send_all(1'b0);
    finish_layer(1'b1, 1'b0, 1'b1);

    // Reset mid-layer with five bytes packed: no write, outputs cleared.
    load_rows(5, 0, 0, 0);
    start_layer(9'd20);
    send_all(1'b0);
    @(negedge clk);
    check("busy_mid", 72'(busy), 72'(1));
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 4'hF;
    @(posedge clk);
    @(negedge clk);
    check("mrst_ready", 72'(req_ready), 72'(0));
    check("mrst_wr_en", 72'(fm_wr_en), 72'(0));
    check("mrst_addr", 72'(fm_wr_addr), 72'(0));
    check("mrst_din", fm_din, 72'(0));
    check("mrst_busy", 72'(busy), 72'(0));
    check("mrst_done", 72'(done), 72'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; req_valid = '0;
    repeat (12) @(posedge clk);
    #1;

    // All four rows valid: grants rotate 0,1,2,3 from a reset pointer.
    load_rows(5, 5, 4, 4);
    slen = 18;
    for (int k = 0; k < slen; k++) stream[k] = bval(k % 4, k / 4);
    push_expected(9'd10);
    start_layer(9'd10);
    send_all(1'b0);
    finish_layer(1'b1, 1'b0, 1'b1);

    // Thirteen bytes from rows 2/3 then flush: second word is zero-padded.
    load_rows(0, 0, 7, 6);
    slen = 13;
    for (int k = 0; k < slen; k++) stream[k] = bval(2 + (k % 2), k / 2);
    push_expected(9'd30);
    start_layer(9'd30);
    send_all(1'b0);
    finish_layer(1'b1, 1'b1, 1'b0);

    // Address wrap 511 -> 0 sets the sticky error.
    load_rows(0, 18, 0, 0);
    slen = 18;
    for (int k = 0; k < slen; k++) stream[k] = bval(1, k);
    push_expected(9'd511);
    start_layer(9'd511);
    send_all(1'b0);
    finish_layer(1'b1, 1'b0, 1'b1);
    check("wrap_set", 72'(wrap_err), 72'(1));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wrap_hold", 72'(wrap_err), 72'(1));

    // Flush coincident with the ninth accept: one full write, no padded extra.
    load_rows(9, 0, 0, 0);
    slen = 9;
    for (int k = 0; k < slen; k++) stream[k] = bval(0, k);
    push_expected(9'd100);
    start_layer(9'd100);
    send_all(1'b1);
    finish_layer(1'b0, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("idle_busy", 72'(busy), 72'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
